xram_arbiter: RTL and testbench

Arbitrating controller for the external 16-bit asynchronous SRAM on the board data bus, whose tristate pads are driven through SB_IO cells in the top level. It serves two requesters:

- the CPU port, 32-bit accesses with byte strobes, each split into two 16-bit SRAM cycles;
- a DMA/video read port, 16-bit reads.

It sequences address, data, drive-enable and the active-low SRAM strobes with a programmable wait count. It sits between `SYSTEM` and the SB_IO pad ring in `main`.

---
 rtl/xram_pkg.sv | 18 +
 rtl/xram_cycle.sv | 107 ++++++++++
 rtl/xram_arbiter.sv | 170 +++++++++++++++++
 tb/tb_xram_arbiter.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/xram_pkg.sv
// Shared types and constants for the external SRAM arbiter.
// Imported by the arbiter top and its access sequencer.
package xram_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACC,
    S_WT,
    S_REC,
    S_DONE
  } state_t;

  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_DMA = 1'b1;

  localparam logic STB_OFF = 1'b1;

endpackage

// File: rtl/xram_cycle.sv
// One 16-bit asynchronous SRAM access: ACC, optional WT, REC.
// Pad controls are decoded from the registered state only.
module xram_cycle
  import xram_pkg::*;
#(
  parameter int AW   = 18,
  parameter int WAIT = 1
) (
  input  logic          clk,
  input  logic          resetb,
  input  logic          start_i,
  input  logic          rd_i,
  input  logic [AW-1:0] addr_i,
  input  logic [15:0]   data_i,
  input  logic [1:0]    ben_i,
  input  logic [15:0]   xdi_i,
  output logic          end_o,
  output logic          cap_o,
  output logic [15:0]   rword_o,
  output logic [AW-1:0] xa_o,
  output logic [15:0]   xdo_o,
  output logic          xdrv_o,
  output logic          xoeb_o,
  output logic          xweb_o,
  output logic          xbheb_o,
  output logic          xbleb_o
);

  localparam logic [2:0] WLD =
    3'((WAIT > 0) ? WAIT - 1 : 0);

  state_t        st_q, st_d;
  logic [2:0]    cnt_q, cnt_d;
  logic          rd_q, rd_d;
  logic [AW-1:0] xa_q, xa_d;
  logic [15:0]   xdo_q, xdo_d;
  logic [1:0]    ben_q, ben_d;
  logic          act;
  logic          drv_ph;

  always_comb begin
    st_d  = st_q;
    cnt_d = cnt_q;
    rd_d  = rd_q;
    xa_d  = xa_q;
    xdo_d = xdo_q;
    ben_d = ben_q;
    if (start_i) begin
      rd_d  = rd_i;
      xa_d  = addr_i;
      xdo_d = data_i;
      ben_d = ben_i;
    end
    unique case (st_q)
      S_IDLE: if (start_i) st_d = S_ACC;
      S_ACC: begin
        if (WAIT == 0) begin
          st_d = S_REC;
        end else begin
          st_d  = S_WT;
          cnt_d = WLD;
        end
      end
      S_WT: begin
        if (cnt_q == 3'd0) st_d = S_REC;
        else cnt_d = cnt_q - 3'd1;
      end
      S_REC: st_d = start_i ? S_ACC : S_IDLE;
      default: st_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetb) begin
      st_q  <= S_IDLE;
      cnt_q <= '0;
      rd_q  <= 1'b1;
      xa_q  <= '0;
      xdo_q <= '0;
      ben_q <= {2{STB_OFF}};
    end else begin
      st_q  <= st_d;
      cnt_q <= cnt_d;
      rd_q  <= rd_d;
      xa_q  <= xa_d;
      xdo_q <= xdo_d;
      ben_q <= ben_d;
    end
  end

  // WE# rises entering REC; address, data and lanes stay put
  assign act    = (st_q == S_ACC) || (st_q == S_WT)
               || (st_q == S_REC);
  assign drv_ph = (st_q == S_ACC) || (st_q == S_WT);

  assign end_o   = (st_q == S_REC);
  assign cap_o   = end_o && rd_q;
  assign rword_o = xdi_i;
  assign xa_o    = xa_q;
  assign xdo_o   = xdo_q;
  assign xdrv_o  = act && !rd_q;
  assign xoeb_o  = !(act && rd_q);
  assign xweb_o  = !(drv_ph && !rd_q);
  assign xbheb_o = act ? ben_q[1] : STB_OFF;
  assign xbleb_o = act ? ben_q[0] : STB_OFF;

endmodule

// File: rtl/xram_arbiter.sv
// Round-robin CPU/DMA arbiter for the 16-bit external SRAM.
// CPU words run as two halves, skipping write halves with no lanes.
module xram_arbiter
  import xram_pkg::*;
#(
  parameter int AW   = 18,
  parameter int WAIT = 1
) (
  input  logic          clk,
  input  logic          resetb,
  input  logic          cpu_valid,
  input  logic [AW-2:0] cpu_addr,
  input  logic [3:0]    cpu_wstrb,
  input  logic [31:0]   cpu_wdata,
  output logic [31:0]   cpu_rdata,
  output logic          cpu_ready,
  input  logic          dma_valid,
  input  logic [AW-1:0] dma_addr,
  output logic [15:0]   dma_rdata,
  output logic          dma_ready,
  output logic [AW-1:0] xa,
  output logic [15:0]   xdo,
  input  logic [15:0]   xdi,
  output logic          xdrv,
  output logic          xoeb,
  output logic          xweb,
  output logic          xbheb,
  output logic          xbleb
);

  state_t        st_q, st_d;
  logic          gnt_q, gnt_d;
  logic          last_q, last_d;
  logic          half_q, half_d;
  logic [AW-2:0] caddr_q, caddr_d;
  logic [3:0]    wstrb_q, wstrb_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   crd_q, crd_d;
  logic [15:0]   drd_q, drd_d;

  logic          start;
  logic          rd;
  logic [AW-1:0] addr;
  logic [15:0]   wd;
  logic [1:0]    ben;
  logic          cyc_end;
  logic          cap;
  logic [15:0]   rword;

  always_comb begin
    st_d    = st_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    half_d  = half_q;
    caddr_d = caddr_q;
    wstrb_d = wstrb_q;
    wdata_d = wdata_q;
    crd_d   = crd_q;
    drd_d   = drd_q;
    start   = 1'b0;
    rd      = 1'b1;
    addr    = '0;
    wd      = '0;
    ben     = {2{STB_OFF}};
    if (cap) begin
      if (gnt_q == REQ_DMA) drd_d = rword;
      else if (half_q) crd_d[31:16] = rword;
      else crd_d[15:0] = rword;
    end
    unique case (st_q)
      S_IDLE: begin
        if (cpu_valid || dma_valid) begin
          gnt_d = (cpu_valid && dma_valid) ? ~last_q
                : (dma_valid ? REQ_DMA : REQ_CPU);
          last_d = gnt_d;
          start  = 1'b1;
          st_d   = S_ACC;
          if (gnt_d == REQ_DMA) begin
            addr = dma_addr;
            ben  = 2'b00;
          end else begin
            caddr_d = cpu_addr;
            wstrb_d = cpu_wstrb;
            wdata_d = cpu_wdata;
            rd      = (cpu_wstrb == 4'd0);
            half_d  = !rd && (cpu_wstrb[1:0] == 2'd0);
            addr    = {cpu_addr, half_d};
            wd      = half_d ? cpu_wdata[31:16]
                             : cpu_wdata[15:0];
            ben     = rd ? 2'b00
                    : (half_d ? ~cpu_wstrb[3:2]
                              : ~cpu_wstrb[1:0]);
          end
        end
      end
      S_ACC: begin
        if (cyc_end) begin
          if (gnt_q == REQ_CPU && !half_q
              && (wstrb_q == 4'd0
                  || wstrb_q[3:2] != 2'd0)) begin
            half_d = 1'b1;
            start  = 1'b1;
            rd     = (wstrb_q == 4'd0);
            addr   = {caddr_q, 1'b1};
            wd     = wdata_q[31:16];
            ben    = rd ? 2'b00 : ~wstrb_q[3:2];
          end else begin
            st_d = S_DONE;
          end
        end
      end
      S_DONE: st_d = S_IDLE;
      default: st_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetb) begin
      st_q    <= S_IDLE;
      gnt_q   <= REQ_CPU;
      last_q  <= REQ_CPU;
      half_q  <= 1'b0;
      caddr_q <= '0;
      wstrb_q <= '0;
      wdata_q <= '0;
      crd_q   <= '0;
      drd_q   <= '0;
    end else begin
      st_q    <= st_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      half_q  <= half_d;
      caddr_q <= caddr_d;
      wstrb_q <= wstrb_d;
      wdata_q <= wdata_d;
      crd_q   <= crd_d;
      drd_q   <= drd_d;
    end
  end

  xram_cycle #(
    .AW   (AW),
    .WAIT (WAIT)
  ) u_cycle (
    .clk     (clk),
    .resetb  (resetb),
    .start_i (start),
    .rd_i    (rd),
    .addr_i  (addr),
    .data_i  (wd),
    .ben_i   (ben),
    .xdi_i   (xdi),
    .end_o   (cyc_end),
    .cap_o   (cap),
    .rword_o (rword),
    .xa_o    (xa),
    .xdo_o   (xdo),
    .xdrv_o  (xdrv),
    .xoeb_o  (xoeb),
    .xweb_o  (xweb),
    .xbheb_o (xbheb),
    .xbleb_o (xbleb)
  );

  assign cpu_ready = (st_q == S_DONE) && (gnt_q == REQ_CPU);
  assign dma_ready = (st_q == S_DONE) && (gnt_q == REQ_DMA);
  assign cpu_rdata = crd_q;
  assign dma_rdata = drd_q;

endmodule

// File: tb/tb_xram_arbiter.sv
// Randomized scoreboard bench for xram_arbiter with an SRAM pin model
// and a transaction-level reference of arbitration, latency and data.
module tb_xram_arbiter;

  localparam int AW = 18;
  localparam int W  = 1;
  localparam int NR = 120;

  logic          clk = 1'b0;
  logic          resetb;
  logic          cpu_valid;
  logic [AW-2:0] cpu_addr;
  logic [3:0]    cpu_wstrb;
  logic [31:0]   cpu_wdata;
  logic [31:0]   cpu_rdata;
  logic          cpu_ready;
  logic          dma_valid;
  logic [AW-1:0] dma_addr;
  logic [15:0]   dma_rdata;
  logic          dma_ready;
  logic [AW-1:0] xa;
  logic [15:0]   xdo;
  logic [15:0]   xdi;
  logic          xdrv, xoeb, xweb, xbheb, xbleb;

  logic          z_cpu_valid;
  logic [AW-2:0] z_cpu_addr;
  logic [3:0]    z_cpu_wstrb;
  logic [31:0]   z_cpu_wdata;
  logic [31:0]   z_cpu_rdata;
  logic          z_cpu_ready;
  logic          z_dma_valid;
  logic [AW-1:0] z_dma_addr;
  logic [15:0]   z_dma_rdata;
  logic          z_dma_ready;
  logic [AW-1:0] z_xa;
  logic [15:0]   z_xdo;
  logic [15:0]   z_xdi;
  logic          z_xdrv, z_xoeb, z_xweb, z_xbheb, z_xbleb;

  always #5 clk = ~clk;

  xram_arbiter #(.AW(AW), .WAIT(W)) dut (
    .clk(clk), .resetb(resetb),
    .cpu_valid(cpu_valid), .cpu_addr(cpu_addr),
    .cpu_wstrb(cpu_wstrb), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
    .dma_valid(dma_valid), .dma_addr(dma_addr),
    .dma_rdata(dma_rdata), .dma_ready(dma_ready),
    .xa(xa), .xdo(xdo), .xdi(xdi), .xdrv(xdrv),
    .xoeb(xoeb), .xweb(xweb), .xbheb(xbheb), .xbleb(xbleb)
  );

  xram_arbiter #(.AW(AW), .WAIT(0)) dut_w0 (
    .clk(clk), .resetb(resetb),
    .cpu_valid(z_cpu_valid), .cpu_addr(z_cpu_addr),
    .cpu_wstrb(z_cpu_wstrb), .cpu_wdata(z_cpu_wdata),
    .cpu_rdata(z_cpu_rdata), .cpu_ready(z_cpu_ready),
    .dma_valid(z_dma_valid), .dma_addr(z_dma_addr),
    .dma_rdata(z_dma_rdata), .dma_ready(z_dma_ready),
    .xa(z_xa), .xdo(z_xdo), .xdi(z_xdi), .xdrv(z_xdrv),
    .xoeb(z_xoeb), .xweb(z_xweb), .xbheb(z_xbheb),
    .xbleb(z_xbleb)
  );

  int vec = 0;
  int bad = 0;
  int cyc = 0;
  int viol = 0;

  task automatic chk(input string n, input longint a,
                     input longint x);
    vec++;
    if (a !== x) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", n, a, x);
    end
  endtask

  // SRAM pin model: reads are combinational, writes latch on WE# rise
  logic [15:0] sram    [1024];
  logic [15:0] ref_mem [1024];
  logic        pv = 1'b0;
  logic [9:0]  pa;
  logic [15:0] pd;
  logic        pbh, pbl;

  assign xdi   = xoeb ? 16'hDEAD : sram[xa[9:0]];
  assign z_xdi = z_xoeb ? 16'hDEAD : 16'h5A5A;

  always @(negedge clk) begin
    if (xweb === 1'b0) begin
      pv  = 1'b1;
      pa  = xa[9:0];
      pd  = xdo;
      pbh = xbheb;
      pbl = xbleb;
    end else if (pv) begin
      pv = 1'b0;
      if (!pbl) sram[pa][7:0] = pd[7:0];
      if (!pbh) sram[pa][15:8] = pd[15:8];
    end
    if ((xdrv && !xoeb) || (z_xdrv && !z_xoeb)) viol++;
  end

  // Transaction-level reference: grant, completion cycle, data
  typedef struct {
    int          cyc;
    logic [31:0] data;
  } exp_t;

  exp_t        cq[$];
  exp_t        dq[$];
  int          free = 0;
  bit          last_cpu = 1'b1;
  logic [31:0] m_crd = '0;
  logic [15:0] m_drd = '0;
  int          h, done, wi;
  bit          pick_dma;

  function automatic int widx(input logic [AW-2:0] a,
                              input int hi);
    return (int'(a) * 2 + hi) % 1024;
  endfunction

  always @(posedge clk) begin
    if (!resetb) begin
      free     = cyc + 1;
      last_cpu = 1'b1;
      m_crd    = '0;
      m_drd    = '0;
      cq.delete();
      dq.delete();
    end else if (cyc >= free && (cpu_valid || dma_valid)) begin
      pick_dma = dma_valid && (!cpu_valid || last_cpu);
      if (pick_dma) begin
        m_drd    = ref_mem[int'(dma_addr) % 1024];
        done     = cyc + 3 + W;
        dq.push_back('{done, {16'h0, m_drd}});
        last_cpu = 1'b0;
      end else begin
        if (cpu_wstrb == 4'd0) begin
          h     = 2;
          m_crd = {ref_mem[widx(cpu_addr, 1)],
                   ref_mem[widx(cpu_addr, 0)]};
        end else begin
          h = 0;
          if (cpu_wstrb[1:0] != 2'd0) h++;
          if (cpu_wstrb[3:2] != 2'd0) h++;
          for (int b = 0; b < 4; b++) begin
            if (cpu_wstrb[b]) begin
              wi = widx(cpu_addr, b / 2);
              ref_mem[wi][(b % 2) * 8 +: 8] =
                cpu_wdata[b * 8 +: 8];
            end
          end
        end
        done     = cyc + 1 + h * (2 + W);
        cq.push_back('{done, m_crd});
        last_cpu = 1'b1;
      end
      free = done + 1;
    end
    cyc++;
  end

  // Monitor: every ready pops the matching expectation
  exp_t me;

  always @(negedge clk) begin
    if (cpu_ready) begin
      if (cq.size() == 0) begin
        chk("cpu_ready_unexpected", cyc, -1);
      end else begin
        me = cq.pop_front();
        chk("cpu_ready_cycle", cyc, me.cyc);
        chk("cpu_rdata", cpu_rdata, me.data);
      end
    end else if (cq.size() > 0 && cq[0].cyc < cyc) begin
      me = cq.pop_front();
      chk("cpu_ready_missing", cyc, me.cyc);
    end
    if (dma_ready) begin
      if (dq.size() == 0) begin
        chk("dma_ready_unexpected", cyc, -1);
      end else begin
        me = dq.pop_front();
        chk("dma_ready_cycle", cyc, me.cyc);
        chk("dma_rdata", dma_rdata, me.data);
      end
    end else if (dq.size() > 0 && dq[0].cyc < cyc) begin
      me = dq.pop_front();
      chk("dma_ready_missing", cyc, me.cyc);
    end
  end

  task automatic cpu_req(input logic [AW-2:0] a,
                         input logic [3:0] s,
                         input logic [31:0] d);
    bit ok = 1'b0;
    cpu_addr  = a;
    cpu_wstrb = s;
    cpu_wdata = d;
    cpu_valid = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (cpu_ready) begin
        ok = 1'b1;
        break;
      end
    end
    cpu_valid = 1'b0;
    if (!ok) chk("cpu_timeout", 0, 1);
  endtask

  task automatic dma_req(input logic [AW-1:0] a);
    bit ok = 1'b0;
    dma_addr  = a;
    dma_valid = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (dma_ready) begin
        ok = 1'b1;
        break;
      end
    end
    dma_valid = 1'b0;
    if (!ok) chk("dma_timeout", 0, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  logic [15:0] old20, old21;
  int          got, n_oe;

  initial begin
    resetb      = 1'b0;
    cpu_valid   = 1'b0;
    cpu_addr    = '0;
    cpu_wstrb   = '0;
    cpu_wdata   = '0;
    dma_valid   = 1'b0;
    dma_addr    = '0;
    z_cpu_valid = 1'b0;
    z_cpu_addr  = '0;
    z_cpu_wstrb = '0;
    z_cpu_wdata = '0;
    z_dma_valid = 1'b0;
    z_dma_addr  = '0;
    for (int i = 0; i < 1024; i++) begin
      sram[i]    = 16'($urandom);
      ref_mem[i] = sram[i];
    end
    sram[10'h200]    = 16'hBEEF;
    ref_mem[10'h200] = 16'hBEEF;
    sram[10'h201]    = 16'hCAFE;
    ref_mem[10'h201] = 16'hCAFE;

    repeat (3) @(negedge clk);
    chk("rst_strobes", {xoeb, xweb, xbheb, xbleb, xdrv},
        5'b11110);
    chk("rst_xa", xa, 0);
    chk("rst_xdo", xdo, 0);
    chk("rst_ready", {cpu_ready, dma_ready}, 0);
    chk("rst_rdata", {cpu_rdata, dma_rdata}, 0);
    resetb = 1'b1;

    fork
      cpu_req(17'h100, 4'b0000, 32'h0);
      dma_req(18'h7);
    join
    chk("cpu_read_tie", cpu_rdata, 32'hCAFEBEEF);
    cpu_req(17'h100, 4'b0000, 32'h0);
    chk("cpu_read_solo", cpu_rdata, 32'hCAFEBEEF);

    old20 = sram[10'h20];
    old21 = sram[10'h21];
    cpu_req(17'h10, 4'b0100, 32'h11223344);
    chk("wr_half0_skipped", sram[10'h20], old20);
    chk("wr_half1_lane", sram[10'h21], {old21[15:8], 8'h22});
    chk("wr_keeps_rdata", cpu_rdata, 32'hCAFEBEEF);

    fork
      cpu_req(17'h5, 4'b0000, 32'h0);
      begin
        repeat (3) @(negedge clk);
        dma_req(18'h9);
      end
    join

    z_dma_addr  = 18'h123;
    z_dma_valid = 1'b1;
    got  = -1;
    n_oe = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (!z_xoeb) n_oe++;
      if (z_dma_ready) begin
        got = k;
        break;
      end
    end
    z_dma_valid = 1'b0;
    chk("w0_dma_latency", got, 3);
    chk("w0_oe_cycles", n_oe, 2);
    chk("w0_dma_rdata", z_dma_rdata, 16'h5A5A);

    fork
      for (int i = 0; i < NR; i++) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        if ($urandom_range(0, 1) == 0)
          cpu_req(17'($urandom_range(0, 31)), 4'd0, 32'd0);
        else
          cpu_req(17'($urandom_range(0, 31)),
                  4'($urandom_range(1, 15)), $urandom);
      end
      for (int i = 0; i < NR; i++) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        dma_req(18'($urandom_range(0, 63)));
      end
    join

    for (int k = 0; k < 100; k++) begin
      if (cq.size() == 0 && dq.size() == 0) break;
      @(negedge clk);
    end
    chk("drain", cq.size() + dq.size(), 0);
    repeat (2) @(negedge clk);

    cpu_addr  = 17'h180;
    cpu_wstrb = 4'hF;
    cpu_wdata = $urandom;
    cpu_valid = 1'b1;
    repeat (5) @(negedge clk);
    chk("pre_rst_half1_we", xweb, 0);
    resetb    = 1'b0;
    cpu_valid = 1'b0;
    @(negedge clk);
    chk("rst_mid_xweb", xweb, 1);
    chk("rst_mid_xdrv", xdrv, 0);
    chk("rst_mid_strobes", {xoeb, xbheb, xbleb}, 3'b111);
    chk("rst_mid_no_ready", cpu_ready, 0);
    resetb = 1'b1;
    dma_req(18'd11);
    repeat (3) @(negedge clk);

    for (int i = 0; i < 64; i++)
      chk($sformatf("mem_%0d", i), sram[i], ref_mem[i]);
    chk("bus_turnaround", viol, 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vec, bad);
    $finish;
  end

endmodule
